// File: rtl/alu_arbiter_if.sv
// Request/response bundle shared by alu_arbiter and the agents that drive it.
// The slave modport is the arbiter's view; the master modport is the requesters/consumer side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_x;
    logic [15:0] req0_y;
    logic [5:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_x;
    logic [15:0] req1_y;
    logic [5:0]  req1_op;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resp_data;
    logic        resp_zr;
    logic        resp_ng;
    logic        resp_err;

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_op,
        input  req1_valid, req1_x, req1_y, req1_op,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_zr, resp_ng, resp_err,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_x, req0_y, req0_op,
        output req1_valid, req1_x, req1_y, req1_op,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_zr, resp_ng, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one Hack-style 16-bit ALU with a registered response slot.
// Optional per-requester saturating accept counters when ALU_ARB_STATS_EN is defined.
module alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [5:0]  op_i,
    output logic [15:0] out_o,
    output logic        legal_o
);
    logic [15:0] x1, x2, y1, y2, f_out;

    always_comb begin
        x1    = op_i[5] ? '0 : x_i;
        x2    = op_i[4] ? ~x1 : x1;
        y1    = op_i[3] ? '0 : y_i;
        y2    = op_i[2] ? ~y1 : y1;
        f_out = op_i[1] ? (x2 + y2) : (x2 & y2);
        out_o = op_i[0] ? ~f_out : f_out;
    end

    always_comb begin
        case (op_i)
            6'b101010, 6'b111111, 6'b111010, 6'b001100,
            6'b110000, 6'b001101, 6'b110001, 6'b001111,
            6'b110011, 6'b011111, 6'b110111, 6'b000010,
            6'b010011, 6'b000111, 6'b000000, 6'b010101: legal_o = 1'b1;
            default:                                    legal_o = 1'b0;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);
    logic        slot_free;
    logic        grant0, grant1, accept;
    logic [15:0] sel_x, sel_y, alu_out;
    logic [5:0]  sel_op;
    logic        alu_legal;
    logic [15:0] result;

    // last_q = 1 means requester 1 was granted most recently
    logic        last_q, last_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic        resp_zr_q, resp_zr_d;
    logic        resp_ng_q, resp_ng_d;
    logic        resp_err_q, resp_err_d;

    // Readies are forced low while reset is held, even though the slot looks free.
    always_comb begin
        slot_free = !resp_valid_q || bus.resp_ready;
        grant0    = rst_n && slot_free && bus.req0_valid && (!bus.req1_valid || last_q);
        grant1    = rst_n && slot_free && bus.req1_valid && (!bus.req0_valid || !last_q);
        accept    = grant0 || grant1;
        sel_x     = grant1 ? bus.req1_x  : bus.req0_x;
        sel_y     = grant1 ? bus.req1_y  : bus.req0_y;
        sel_op    = grant1 ? bus.req1_op : bus.req0_op;
    end

    alu u_alu (
        .x_i     (sel_x),
        .y_i     (sel_y),
        .op_i    (sel_op),
        .out_o   (alu_out),
        .legal_o (alu_legal)
    );

    always_comb begin
        result       = alu_legal ? alu_out : '0;
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_zr_d    = resp_zr_q;
        resp_ng_d    = resp_ng_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            last_d       = grant1;
            resp_valid_d = 1'b1;
            resp_id_d    = grant1;
            resp_data_d  = result;
            resp_zr_d    = (result == '0);
            resp_ng_d    = result[15];
            resp_err_d   = !alu_legal;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_zr_q    <= 1'b0;
            resp_ng_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_zr_q    <= resp_zr_d;
            resp_ng_q    <= resp_ng_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_zr    = resp_zr_q;
    assign bus.resp_ng    = resp_ng_q;
    assign bus.resp_err   = resp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (grant0 && cnt0_q != '1) cnt0_d = cnt0_q + 16'd1;
        if (grant1 && cnt1_q != '1) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; inputs change 1 ns after the rising edge,
// combinational readies are sampled 1 ns later and registered outputs 1 ns after the next edge.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;

    alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );
`else
    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [5:0] op);
        bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [5:0] op);
        bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_op = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_data",  {16'd0, bus.resp_data}, 32'd0);
        check("rst_flags", {28'd0, bus.resp_id, bus.resp_zr, bus.resp_ng, bus.resp_err}, 32'd0);
        check("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    logic exp_id [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        bus.resp_ready = 1'b1;
        drive0(1'b1, 16'd5, 16'd3, 6'b000010);
        drive1(1'b0, 16'd0, 16'd0, 6'b000000);
        tick();
        apply_reset();

        // single requester 0: 5 + 3
        #1;
        check("t1_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b10);
        tick();
        drive0(1'b0, 16'd0, 16'd0, 6'b000000);
        check("t1_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("t1_data",  {16'd0, bus.resp_data}, 32'd8);
        check("t1_flags", {28'd0, bus.resp_id, bus.resp_zr, bus.resp_ng, bus.resp_err}, 32'd0);
        tick();
        check("t1_drain", {31'd0, bus.resp_valid}, 32'd0);

        // single requester 1: ~y with y=00FF
        drive1(1'b1, 16'h1234, 16'h00FF, 6'b110001);
        #1;
        check("t1b_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b01);
        tick();
        drive1(1'b0, 16'd0, 16'd0, 6'b000000);
        check("t1b_data",  {16'd0, bus.resp_data}, 32'h0000FF00);
        check("t1b_flags", {28'd0, bus.resp_id, bus.resp_zr, bus.resp_ng, bus.resp_err}, 32'b1010);
        tick();

        // contention right after reset: 0,1,0,1
        apply_reset();
        drive0(1'b1, 16'd5, 16'd3, 6'b000010);
        drive1(1'b1, 16'd3, 16'd5, 6'b010011);
        exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", {30'd0, bus.req0_ready, bus.req1_ready},
                  exp_id[i] ? 32'b01 : 32'b10);
            tick();
            check("rr_id", {31'd0, bus.resp_id}, {31'd0, exp_id[i]});
            check("rr_data", {16'd0, bus.resp_data}, exp_id[i] ? 32'h0000FFFE : 32'd8);
        end
        check("rr_ng", {31'd0, bus.resp_ng}, 32'd1);

        // back-pressure: response held for 3 cycles, no accepts
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b00);
            tick();
            check("hold_resp", {bus.resp_valid, bus.resp_id, bus.resp_ng, 13'd0, bus.resp_data},
                  {3'b111, 13'd0, 16'hFFFE});
        end
        bus.resp_ready = 1'b1;
        #1;
        check("release_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b10);
        tick();
        check("release_resp", {15'd0, bus.resp_id, bus.resp_data}, 32'd8);
        drive0(1'b0, 16'd0, 16'd0, 6'b000000);
        drive1(1'b0, 16'd0, 16'd0, 6'b000000);
        tick();

        // illegal opcode then a legal -x
        drive0(1'b1, 16'd7, 16'd9, 6'b101011);
        tick();
        check("ill_resp", {bus.resp_valid, bus.resp_err, bus.resp_zr, bus.resp_ng, 12'd0, bus.resp_data},
              {4'b1110, 28'd0});
        drive0(1'b1, 16'd1, 16'd0, 6'b001111);
        tick();
        check("neg_resp", {bus.resp_valid, bus.resp_err, bus.resp_zr, bus.resp_ng, 12'd0, bus.resp_data},
              {4'b1001, 12'd0, 16'hFFFF});

        // async reset while a response is held
        drive0(1'b1, 16'd2, 16'd2, 6'b000010);
        bus.resp_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, bus.resp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {15'd0, bus.resp_valid, bus.resp_data}, 32'd0);
        #1;
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        drive1(1'b1, 16'd0, 16'd0, 6'b111111);
        #1;
        check("post_rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b10);
        tick();
        check("post_rst_id", {15'd0, bus.resp_id, bus.resp_data}, 32'd4);
        drive0(1'b0, 16'd0, 16'd0, 6'b000000);
        drive1(1'b0, 16'd0, 16'd0, 6'b000000);
        tick();

`ifdef ALU_ARB_STATS_EN
        apply_reset();
        check("cnt_rst", {grant_cnt0, grant_cnt1}, 32'd0);
        drive0(1'b1, 16'd1, 16'd1, 6'b000010);
        for (int i = 0; i < 70000; i++) tick();
        drive0(1'b0, 16'd0, 16'd0, 6'b000000);
        tick();
        check("cnt_sat", {grant_cnt0, grant_cnt1}, {16'hFFFF, 16'h0000});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; datapath width fixed at 16 bits, opcode fixed at 6 bits {zx,nx,zy,ny,f,no}.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester k's operation is accepted this cycle (combinational).
REQ-006 req0_x, req0_y / req1_x, req1_y  input  16  operands of requester k.
REQ-007 req0_op / req1_op  input  6  ALU control word of requester k.
REQ-008 resp_valid  output  1  response register holds a result.
REQ-009 resp_ready  input  1  consumer takes the response this cycle.
REQ-010 resp_id  output  1  index of the requester that owns the response.
REQ-011 resp_data  output  16  ALU result.
REQ-012 resp_zr / resp_ng  output  1  result == 0 / result[15].
REQ-013 resp_err  output  1  opcode was not one of the 16 legal codes.
REQ-014 grant_cnt0 / grant_cnt1  output  16  per-requester accept counters (present only with ALU_ARB_STATS_EN).

Function
REQ-015 Block SHALL instantiate one alu and share it between the two requesters; at most one request accepted per cycle.
REQ-016 Transfer on a request port occurs when reqk_valid && reqk_ready; on the response port when resp_valid && resp_ready.
REQ-017 Response slot is free when resp_valid==0 or resp_ready==1 in the same cycle; no request SHALL be accepted while the slot is not free.
REQ-018 With the slot free and exactly one valid requester, that requester SHALL be granted.
REQ-019 With the slot free and both valid, the requester not granted most recently SHALL be granted (round-robin); last-grant pointer updates only on an accept.
REQ-020 A requester continuously valid SHALL be accepted within two accepts of the block (no starvation).
REQ-021 reqk_ready SHALL be 0 for the non-granted requester and whenever the slot is not free; it SHALL NOT depend on reqk_ready of the other port.
REQ-022 Latency: request accepted at edge N SHALL appear with resp_valid=1 after edge N (one cycle); back-to-back accepts sustain one result per cycle when resp_ready stays 1.
REQ-023 Legal opcodes: 101010, 111111, 111010, 001100, 110000, 001101, 110001, 001111, 110011, 011111, 110111, 000010, 010011, 000111, 000000, 010101, with Hack ALU semantics (0, 1, -1, x, y, ~x, ~y, -x, -y, x+1, y+1, x+y, x-y, y-x, x&y, x|y).
REQ-024 Arithmetic SHALL wrap modulo 2^16; no carry or overflow output.
REQ-025 Illegal opcode: request SHALL still be accepted and arbitrated normally; response carries resp_err=1, resp_data=0, resp_zr=1, resp_ng=0.
REQ-026 Response fields SHALL be registered and held stable while resp_valid=1 and resp_ready=0.
REQ-027 Response register SHALL capture operands-derived result only from the accepted request, never from the ALU output of a non-accepted cycle.

Reset
REQ-028 While rst_n=0: resp_valid=0, resp_id=0, resp_data=0, resp_zr=0, resp_ng=0, resp_err=0, both ready outputs 0, last-grant pointer = 1 (so requester 0 wins first contention), counters 0.
REQ-029 Reset asserted mid-transfer SHALL discard any held response; no partial state survives.

Configuration
REQ-030 Macro ALU_ARB_STATS_EN defined: grant_cnt0/grant_cnt1 ports exist, each increments on its requester's accept and saturates at 16'hFFFF.
REQ-031 Macro ALU_ARB_STATS_EN undefined: counter ports and logic are absent; all other behaviour identical.

Verification
REQ-032 req0 only, x=5, y=3, op=000010, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_data=8, zr=0, ng=0, err=0.
REQ-033 Both valid every cycle after reset, resp_ready=1 -> accept order 0,1,0,1; req1 op=010011 x=3 y=5 -> resp_data=16'hFFFE, ng=1.
REQ-034 Response held, resp_ready=0 for 3 cycles with both valid -> both ready=0, resp fields unchanged; resp_ready=1 -> new accept same cycle, new result next cycle.
REQ-035 req0 op=101011 -> resp_err=1, resp_data=0, zr=1; following legal op 001111 x=1 -> resp_data=16'hFFFF, err=0.
REQ-036 rst_n pulsed low while resp_valid=1 -> resp_valid=0 immediately (async); after release first contention grants requester 0.
REQ-037 With ALU_ARB_STATS_EN, 70000 accepts on req0 -> grant_cnt0=16'hFFFF, grant_cnt1=0.
